cnn_bn_relu_07: RTL and testbench

- Streaming per-output-channel affine (folded batch-norm) plus ReLU stage, placed directly downstream of the conv_07 3x3 layer.
- Consumes the layer's aligned pxl_out/valid_out stream and computes y = max(0, x*scale[c] + bias[c]).
- Scale/bias pairs are loaded once through a serial parameter port before the first frame, then reused for every frame.
- Output feeds the next layer's loop-data block.

---
 rtl/cnn_bn_relu_07.sv | 218 +++++++++++++++++++++
 tb/tb_cnn_bn_relu_07.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_bn_relu_07.sv
// Folded batch-norm (per-channel scale/bias) plus ReLU, streaming stage.
// Sits behind the conv_07 3x3 layer. It computes max(0, x*scale[c] + bias[c])
// with a fixed 3-cycle latency from valid_in to valid_out.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | parameter words are written to the RAM; pixels are rejected
//   RUN   | pixels stream through; a reload is taken only at a frame
//         | boundary while the pipeline is empty
module cnn_bn_relu_07 #(
  parameter int DATA_WIDTH         = 32,
  parameter int FRAC_BITS          = 16,
  parameter int CHANNEL_NUM_OUT    = 256,
  parameter int PIXELS_PER_CHANNEL = 256,
  parameter int CH_CNT_WIDTH       = 8,
  parameter int PX_CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_param_in,
  input  logic [DATA_WIDTH-1:0] param_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  param_ready,
  output logic                  frame_done,
  output logic                  err_out
);

  localparam int DW     = DATA_WIDTH;
  localparam int WIDX_W = CH_CNT_WIDTH + 1;

  localparam logic [WIDX_W-1:0]       WIDX_LAST = WIDX_W'(2 * CHANNEL_NUM_OUT - 1);
  localparam logic [CH_CNT_WIDTH-1:0] CH_LAST   = CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);
  localparam logic [PX_CNT_WIDTH-1:0] PX_LAST   = PX_CNT_WIDTH'(PIXELS_PER_CHANNEL - 1);

  localparam logic signed [2*DW-1:0] PROD_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] PROD_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]          WORD_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          WORD_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t state_q, state_d;
  logic [WIDX_W-1:0]       widx_q, widx_d;
  logic [CH_CNT_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
  logic [PX_CNT_WIDTH-1:0] px_cnt_q, px_cnt_d;
  logic                    param_ready_q, param_ready_d;
  logic                    err_q, err_d;

  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_last_q, s1_last_d;
  logic [DW-1:0]           s1_x_q, s1_x_d;
  logic [DW-1:0]           s1_scale_q, s1_bias_q;

  logic                    s2_vld_q, s2_vld_d;
  logic                    s2_last_q, s2_last_d;
  logic [DW-1:0]           s2_val_q, s2_val_d;
  logic [DW-1:0]           s2_bias_q, s2_bias_d;

  logic                    out_vld_q, out_vld_d;
  logic                    out_last_q, out_last_d;
  logic [DW-1:0]           pxl_out_q, pxl_out_d;

  logic                    ram_we;
  logic [WIDX_W-1:0]       ram_addr;
  logic                    pix_accept;

  logic [DW-1:0]           scale_mem [CHANNEL_NUM_OUT];
  logic [DW-1:0]           bias_mem  [CHANNEL_NUM_OUT];

  logic signed [2*DW-1:0]  x_ext, scale_ext, prod_full, prod_shift;
  logic [DW-1:0]           prod_sat;
  logic signed [DW:0]      sum;
  logic [DW-1:0]           relu_val;

  // Control FSM: parameter load sequencing, pixel counters and the error flag
  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    ch_cnt_d      = ch_cnt_q;
    px_cnt_d      = px_cnt_q;
    param_ready_d = param_ready_q;
    err_d         = err_q;
    ram_we        = 1'b0;
    ram_addr      = widx_q;
    pix_accept    = 1'b0;
    s1_last_d     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (valid_param_in) begin
          ram_we = 1'b1;
          if (widx_q == WIDX_LAST) begin
            state_d       = S_RUN;
            param_ready_d = 1'b1;
            widx_d        = '0;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
        if (valid_in) err_d = 1'b1;
      end
      S_RUN: begin
        if (valid_in) begin
          pix_accept = 1'b1;
          s1_last_d  = (ch_cnt_q == CH_LAST) && (px_cnt_q == PX_LAST);
          if (px_cnt_q == PX_LAST) begin
            px_cnt_d = '0;
            ch_cnt_d = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_CNT_WIDTH'(1);
          end else begin
            px_cnt_d = px_cnt_q + PX_CNT_WIDTH'(1);
          end
          // A parameter word colliding with a pixel always loses.
          if (valid_param_in) err_d = 1'b1;
        end else if (valid_param_in) begin
          if (ch_cnt_q == '0 && px_cnt_q == '0 && !s1_vld_q && !s2_vld_q) begin
            state_d       = S_LOAD;
            param_ready_d = 1'b0;
            ram_we        = 1'b1;
            ram_addr      = '0;
            widx_d        = WIDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Datapath: S1 capture, S2 fixed-point multiply with saturation, S3 bias add and ReLU
  always_comb begin
    s1_vld_d = pix_accept;
    s1_x_d   = pix_accept ? pxl_in : s1_x_q;

    x_ext      = {{DW{s1_x_q[DW-1]}}, s1_x_q};
    scale_ext  = {{DW{s1_scale_q[DW-1]}}, s1_scale_q};
    prod_full  = x_ext * scale_ext;
    prod_shift = prod_full >>> FRAC_BITS;
    if (prod_shift > PROD_MAX)      prod_sat = WORD_MAX;
    else if (prod_shift < PROD_MIN) prod_sat = WORD_MIN;
    else                            prod_sat = prod_shift[DW-1:0];

    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_vld_q & s1_last_q;
    s2_val_d  = s1_vld_q ? prod_sat : s2_val_q;
    s2_bias_d = s1_vld_q ? s1_bias_q : s2_bias_q;

    // One extra bit keeps the sum exact, so the clamp sees the true sign.
    sum = {s2_val_q[DW-1], s2_val_q} + {s2_bias_q[DW-1], s2_bias_q};
    if (sum[DW])        relu_val = '0;
    else if (sum[DW-1]) relu_val = WORD_MAX;
    else                relu_val = sum[DW-1:0];

    out_vld_d  = s2_vld_q;
    out_last_d = s2_vld_q & s2_last_q;
    pxl_out_d  = s2_vld_q ? relu_val : pxl_out_q;
  end

  // Parameter RAM, with a synchronous read into S1 (contents survive reset)
  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (ram_addr[0]) bias_mem[ram_addr[WIDX_W-1:1]]  <= param_in;
      else             scale_mem[ram_addr[WIDX_W-1:1]] <= param_in;
    end
    if (pix_accept) begin
      s1_scale_q <= scale_mem[ch_cnt_q];
      s1_bias_q  <= bias_mem[ch_cnt_q];
    end
  end

  // State, counter and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_LOAD;
      widx_q        <= '0;
      ch_cnt_q      <= '0;
      px_cnt_q      <= '0;
      param_ready_q <= 1'b0;
      err_q         <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_x_q        <= '0;
      s2_vld_q      <= 1'b0;
      s2_last_q     <= 1'b0;
      s2_val_q      <= '0;
      s2_bias_q     <= '0;
      out_vld_q     <= 1'b0;
      out_last_q    <= 1'b0;
      pxl_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      ch_cnt_q      <= ch_cnt_d;
      px_cnt_q      <= px_cnt_d;
      param_ready_q <= param_ready_d;
      err_q         <= err_d;
      s1_vld_q      <= s1_vld_d;
      s1_last_q     <= s1_last_d;
      s1_x_q        <= s1_x_d;
      s2_vld_q      <= s2_vld_d;
      s2_last_q     <= s2_last_d;
      s2_val_q      <= s2_val_d;
      s2_bias_q     <= s2_bias_d;
      out_vld_q     <= out_vld_d;
      out_last_q    <= out_last_d;
      pxl_out_q     <= pxl_out_d;
    end
  end

  assign pxl_out     = pxl_out_q;
  assign valid_out   = out_vld_q;
  assign param_ready = param_ready_q;
  assign frame_done  = out_last_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_cnn_bn_relu_07.sv
// Bench for cnn_bn_relu_07 with 4 channels of 4 pixels each.
module tb_cnn_bn_relu_07;

  localparam int C    = 4;
  localparam int P    = 4;
  localparam int FB   = 16;
  localparam int NPIX = C * P;
  localparam longint LMAX = 64'sh7FFFFFFF;
  localparam longint LMIN = -64'sh80000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_param_in = 1'b0;
  logic [31:0] param_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic [31:0] pxl_out;
  logic        valid_out, param_ready, frame_done, err_out;

  cnn_bn_relu_07 #(
    .DATA_WIDTH(32), .FRAC_BITS(FB), .CHANNEL_NUM_OUT(C),
    .PIXELS_PER_CHANNEL(P), .CH_CNT_WIDTH(2), .PX_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_param_in(valid_param_in), .param_in(param_in),
    .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out), .valid_out(valid_out),
    .param_ready(param_ready), .frame_done(frame_done), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] val;
    logic        last;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  vec_t tbl[NPIX];

  logic [31:0] ld_w[2*C];
  logic [31:0] sc_m[C];
  logic [31:0] bi_m[C];
  bit          mdl_loaded = 1'b0;
  int          mdl_idx = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: y = max(0, sat(floor(x*s / 2^FB)) + b), clamped to the positive range
  function automatic logic [31:0] ref_out(input logic [31:0] x, input logic [31:0] s,
                                          input logic [31:0] b);
    longint p, q, sum;
    p = longint'($signed(x)) * longint'($signed(s));
    q = p >>> FB;
    if (q > LMAX) q = LMAX;
    else if (q < LMIN) q = LMIN;
    sum = q + longint'($signed(b));
    if (sum < 0) return 32'd0;
    if (sum > LMAX) return 32'h7FFFFFFF;
    return sum[31:0];
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r;
      1:       return {{12{r[19]}}, r[19:0]};
      default: return {{14{r[17]}}, r[17:0]};
    endcase
  endfunction

  // Scoreboard: every valid_out must match the oldest expectation, on its due cycle
  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check32("unexpected_valid_out", {31'b0, valid_out}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check32("pxl_out", pxl_out, mon_e.val);
        check32("frame_done", {31'b0, frame_done}, {31'b0, mon_e.last});
        check32("latency_cycle", cyc, mon_e.due);
      end
    end else begin
      if (frame_done) check32("frame_done_without_valid", {31'b0, frame_done}, 32'd0);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check32("missing_output_cycle", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [31:0] x, input logic [31:0] ev, input bit use_ev,
                         input bit with_param);
    logic [31:0] v;
    int ch;
    valid_in = 1'b1;
    pxl_in   = x;
    valid_param_in = with_param;
    param_in = 32'hA5A5_A5A5;
    if (mdl_loaded) begin
      ch = mdl_idx / P;
      v  = use_ev ? ev : ref_out(x, sc_m[ch], bi_m[ch]);
      exp_q.push_back('{v, (mdl_idx == NPIX - 1), cyc + 3});
      mdl_idx = (mdl_idx + 1) % NPIX;
    end
    tick();
    valid_in = 1'b0;
    valid_param_in = 1'b0;
  endtask

  task automatic load_params();
    mdl_loaded = 1'b0;
    for (int i = 0; i < 2 * C; i++) begin
      valid_param_in = 1'b1;
      param_in = ld_w[i];
      tick();
      check32($sformatf("param_ready_after_word%0d", i), {31'b0, param_ready},
              (i == 2 * C - 1) ? 32'd1 : 32'd0);
    end
    valid_param_in = 1'b0;
    for (int c = 0; c < C; c++) begin
      sc_m[c] = ld_w[2*c];
      bi_m[c] = ld_w[2*c+1];
    end
    mdl_loaded = 1'b1;
    mdl_idx = 0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    check32("drain_pending", exp_q.size(), 32'd0);
    repeat (2) tick();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    exp_q.delete();
    mdl_loaded = 1'b0;
    mdl_idx = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_chan_index_params();
    for (int c = 0; c < C; c++) begin
      ld_w[2*c]   = 32'((c + 1) << 16);
      ld_w[2*c+1] = 32'h0;
    end
  endtask

  initial begin
    tbl = '{
      '{32'h0003_0000, 32'h0000_8000}, '{32'h0001_0000, 32'h0000_0000},
      '{32'h0004_0000, 32'h0001_0000}, '{32'h0005_0001, 32'h0001_8000},
      '{32'h7FFF_0000, 32'h7FFF_FFFF}, '{32'h8000_0000, 32'h0000_0000},
      '{32'h0001_0000, 32'h0003_0000}, '{32'hFFFF_8000, 32'h0000_0000},
      '{32'h1234_5678, 32'h1234_5678}, '{32'hFFFF_FFFF, 32'h0000_0000},
      '{32'h7FFF_FFFF, 32'h7FFF_FFFF}, '{32'h0000_0000, 32'h0000_0000},
      '{32'hFFFF_0000, 32'h0001_8000}, '{32'h0001_0000, 32'h0000_0000},
      '{32'h8000_0000, 32'h7FFF_FFFF}, '{32'h0000_0001, 32'h0000_7FFF}
    };

    // Reset values
    repeat (2) tick();
    check32("rst_pxl_out", pxl_out, 32'd0);
    check32("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check32("rst_param_ready", {31'b0, param_ready}, 32'd0);
    check32("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check32("rst_err_out", {31'b0, err_out}, 32'd0);
    reset = 1'b1;
    tick();

    // Pixel before parameters are loaded: dropped and flagged
    send_px(32'h0003_0000, 32'h0, 1'b0, 1'b0);
    check32("err_pixel_in_load", {31'b0, err_out}, 32'd1);
    repeat (5) tick();
    reset_pulse();
    check32("err_cleared_by_reset", {31'b0, err_out}, 32'd0);

    // Identity parameters, one back-to-back frame
    for (int c = 0; c < C; c++) begin
      ld_w[2*c] = 32'h0001_0000;
      ld_w[2*c+1] = 32'h0;
    end
    load_params();
    for (int i = 0; i < NPIX; i++) send_px(32'h0003_0000, 32'h0003_0000, 1'b1, 1'b0);
    wait_drain();

    // Reload at a frame boundary, then fixed vectors covering rounding, clamp and saturation
    ld_w = '{32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000,
             32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_8000};
    load_params();
    for (int i = 0; i < NPIX; i++) send_px(tbl[i].x, tbl[i].y, 1'b1, 1'b0);
    wait_drain();

    // Channel indexing with gaps; mid-frame parameter word is ignored
    set_chan_index_params();
    load_params();
    check32("err_before_midframe_param", {31'b0, err_out}, 32'd0);
    for (int i = 0; i < NPIX; i++) begin
      send_px(32'h0001_0000, 32'((i / P + 1) << 16), 1'b1, 1'b0);
      if (i == 5) begin
        valid_param_in = 1'b1;
        param_in = 32'hDEAD_BEEF;
        tick();
        valid_param_in = 1'b0;
        check32("err_midframe_param", {31'b0, err_out}, 32'd1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    // Second frame without reload; its first pixel collides with a parameter word
    for (int i = 0; i < NPIX; i++) begin
      send_px(32'h0001_0000, 32'((i / P + 1) << 16), 1'b1, (i == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain();
    check32("param_ready_kept", {31'b0, param_ready}, 32'd1);

    // Random parameters and pixels against the reference model
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 2 * C; w++) ld_w[w] = rnd_word();
      load_params();
      for (int i = 0; i < NPIX; i++) begin
        send_px(rnd_word(), 32'h0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 1)) tick();
      end
      wait_drain();
    end

    // Asynchronous reset with the pipeline full
    set_chan_index_params();
    load_params();
    for (int i = 0; i < 6; i++) send_px(32'h0001_0000, 32'((i / P + 1) << 16), 1'b1, 1'b0);
    check32("pipe_full_valid_out", {31'b0, valid_out}, 32'd1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    mdl_loaded = 1'b0;
    mdl_idx = 0;
    #1;
    check32("async_rst_pxl_out", pxl_out, 32'd0);
    check32("async_rst_valid_out", {31'b0, valid_out}, 32'd0);
    check32("async_rst_param_ready", {31'b0, param_ready}, 32'd0);
    check32("async_rst_frame_done", {31'b0, frame_done}, 32'd0);
    check32("async_rst_err_out", {31'b0, err_out}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    check32("param_ready_after_reset", {31'b0, param_ready}, 32'd0);
    send_px(32'h0001_0000, 32'h0, 1'b0, 1'b0);
    send_px(32'h0002_0000, 32'h0, 1'b0, 1'b0);
    check32("err_pixels_without_reload", {31'b0, err_out}, 32'd1);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
